thumb_fetch_queue: RTL and testbench

Parametrised Thumb instruction-fetch front end for the ARM_Thumb pipeline. It issues word-aligned read requests of configurable bus width to instruction memory and splits each returned word into 16-bit Thumb halfwords. It buffers the halfwords, each paired with its PC, in a configurable-depth queue and presents one halfword per cycle to the ID-stage register (IR2/PC2). It supports branch redirect with discard of in-flight data and unaligned redirect targets. It replaces the fixed two-halfword toggle fetch of the first-generation core.

---
 rtl/thumb_fetch_queue.sv | 166 ++++++++++++++++
 tb/tb_thumb_fetch_queue.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/thumb_fetch_queue.sv
// thumb_fetch_queue
// Thumb instruction-fetch front end. Issues word-aligned reads of FETCH_W bits
// to instruction memory, splits each returned word into 16-bit halfwords and
// queues them with their byte PCs for the ID stage, one halfword per cycle.
// A redirect empties the queue, retargets fetch and discards in-flight data.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   IREQ/IADDR/IRW      memory request, word-aligned address, read-only (0)
//   IACK/INSTR          request accepted, returned word valid same cycle
//   REDIRECT/_PC        branch/flush request and new PC (bit 0 ignored)
//   INST_VALID/INST/    queue head valid, halfword, byte PC
//   INST_PC
//   INST_READY          consumer takes the head this cycle
//
// state | meaning
// IDLE  | no request outstanding
// BUSY  | request outstanding, returned data is wanted
// FLUSH | request outstanding, returned data is stale and dropped
module thumb_fetch_queue #(
  parameter int          FETCH_W      = 32,
  parameter int          DEPTH        = 8,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic               CLK,
  input  logic               RST,
  output logic               IREQ,
  output logic [31:0]        IADDR,
  output logic               IRW,
  input  logic               IACK,
  input  logic [FETCH_W-1:0] INSTR,
  input  logic               REDIRECT,
  input  logic [31:0]        REDIRECT_PC,
  output logic               INST_VALID,
  output logic [15:0]        INST,
  output logic [31:0]        INST_PC,
  input  logic               INST_READY
);

  localparam int N      = FETCH_W / 16;
  localparam int BYTES  = FETCH_W / 8;
  localparam int OFS_W  = $clog2(BYTES);
  localparam int SKIP_W = OFS_W - 1;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0]        state;
  logic [15:0]       hw_mem [DEPTH];
  logic [31:0]       pc_mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [31:0]       fpc;
  logic [SKIP_W-1:0] skip;

  logic              pop;
  logic              accept;
  logic              free_ok;
  logic [CNT_W-1:0]  push_n;
  logic [31:0]       redir_fpc;
  logic [SKIP_W-1:0] redir_skip;
  logic [PTR_W-1:0]  wr_idx [N];
  logic              unused_pc_bit;

  assign IRW        = 1'b0;
  assign INST_VALID = (count != '0);
  assign INST       = hw_mem[rd_ptr];
  assign INST_PC    = pc_mem[rd_ptr];

  assign pop        = INST_VALID && INST_READY;
  // Redirect wins over any data returned in the same cycle.
  assign accept     = (state == S_BUSY) && IACK && !REDIRECT;
  assign push_n     = CNT_W'(N) - CNT_W'(skip);
  // Only the queue is counted: with a single outstanding request, space
  // reserved at issue time cannot be consumed by anything else.
  assign free_ok    = (CNT_W'(DEPTH) - count) >= CNT_W'(N);
  assign redir_fpc  = {REDIRECT_PC[31:OFS_W], OFS_W'(0)};
  assign redir_skip = REDIRECT_PC[OFS_W-1:1];
  assign unused_pc_bit = REDIRECT_PC[0];

  // Halfword i of the accepted word lands i-skip slots past the write pointer.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      wr_idx[i] = wr_ptr + PTR_W'(i) - PTR_W'(skip);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        hw_mem[i] <= '0;
        pc_mem[i] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < N; i++) begin
        if (SKIP_W'(i) >= skip) begin
          hw_mem[wr_idx[i]] <= INSTR[16*i +: 16];
          pc_mem[wr_idx[i]] <= IADDR + 32'(2 * i);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= S_IDLE;
      IREQ   <= 1'b0;
      IADDR  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      fpc    <= {RESET_VECTOR[31:OFS_W], OFS_W'(0)};
      skip   <= RESET_VECTOR[OFS_W-1:1];
    end else if (REDIRECT) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      fpc    <= redir_fpc;
      skip   <= redir_skip;
      if (state == S_IDLE) begin
        // Queue is now empty, so the space check is not needed.
        IREQ  <= 1'b1;
        IADDR <= redir_fpc;
        state <= S_BUSY;
      end else begin
        state <= S_FLUSH;
      end
    end else begin
      rd_ptr <= rd_ptr + PTR_W'(pop);
      wr_ptr <= wr_ptr + (accept ? PTR_W'(push_n) : '0);
      count  <= count + (accept ? push_n : '0) - CNT_W'(pop);
      case (state)
        S_IDLE: begin
          if (free_ok) begin
            IREQ  <= 1'b1;
            IADDR <= fpc;
            state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (IACK) begin
            fpc   <= fpc + 32'(BYTES);
            skip  <= '0;
            IREQ  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_FLUSH: begin
          if (IACK) begin
            IREQ  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          IREQ  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_thumb_fetch_queue.sv
module tb_thumb_fetch_queue;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IREQ;
  logic [31:0] IADDR;
  logic        IRW;
  logic        IACK = 1'b0;
  logic [31:0] INSTR = '0;
  logic        REDIRECT = 1'b0;
  logic [31:0] REDIRECT_PC = '0;
  logic        INST_VALID;
  logic [15:0] INST;
  logic [31:0] INST_PC;
  logic        INST_READY = 1'b1;

  // second instance: 64-bit bus, zero-wait memory, consumer always ready
  logic        ireq64;
  logic [31:0] iaddr64;
  logic        irw64;
  logic        iack64;
  logic [63:0] instr64;
  logic        redir64 = 1'b0;
  logic [31:0] rpc64 = '0;
  logic        valid64;
  logic [15:0] inst64;
  logic [31:0] pc64;
  logic        ready64 = 1'b1;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 0;

  int mem_mode = 0;   // 0 zero-wait, 1 fixed wait, 2 random, 3 never ack
  int wait_n = 0;
  int age = 0;

  // reference model state
  logic [31:0] mq[$];
  bit          m_busy;
  bit          m_stale;
  logic [31:0] m_addr;
  logic [31:0] m_fpc;
  int          m_skip;

  always #5 CLK = ~CLK;

  thumb_fetch_queue #(.FETCH_W(32), .DEPTH(8), .RESET_VECTOR(32'h0)) u_dut (
    .CLK(CLK), .RST(RST), .IREQ(IREQ), .IADDR(IADDR), .IRW(IRW),
    .IACK(IACK), .INSTR(INSTR), .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
    .INST_VALID(INST_VALID), .INST(INST), .INST_PC(INST_PC), .INST_READY(INST_READY)
  );

  thumb_fetch_queue #(.FETCH_W(64), .DEPTH(8), .RESET_VECTOR(32'h0)) u_dut64 (
    .CLK(CLK), .RST(RST), .IREQ(ireq64), .IADDR(iaddr64), .IRW(irw64),
    .IACK(iack64), .INSTR(instr64), .REDIRECT(redir64), .REDIRECT_PC(rpc64),
    .INST_VALID(valid64), .INST(inst64), .INST_PC(pc64), .INST_READY(ready64)
  );

  assign iack64  = ireq64;
  assign instr64 = {iaddr64[15:0] + 16'd6, iaddr64[15:0] + 16'd4,
                    iaddr64[15:0] + 16'd2, iaddr64[15:0]};

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // memory returns word = its own address
  function automatic logic [15:0] exp_hw(logic [31:0] pc);
    logic [31:0] w;
    w = {pc[31:2], 2'b00};
    return pc[1] ? w[31:16] : w[15:0];
  endfunction

  task automatic cyc(int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  // instruction memory for the 32-bit instance
  always @(posedge CLK) begin
    #1;
    if (!IREQ) age = 0;
    case (mem_mode)
      0:       IACK = IREQ;
      1:       IACK = IREQ && (age >= wait_n);
      2:       IACK = IREQ && ($urandom_range(1) == 1);
      default: IACK = 1'b0;
    endcase
    INSTR = IADDR;
    if (IREQ) age = IACK ? 0 : age + 1;
  end

  // behavioural model: queue of PCs plus one outstanding-request record
  always @(posedge CLK) begin
    int sz;
    if (RST) begin
      mq.delete();
      m_busy = 0; m_stale = 0; m_addr = '0;
      m_fpc = 32'h0; m_skip = 0;
    end else if (REDIRECT) begin
      mq.delete();
      m_fpc  = REDIRECT_PC & ~32'h3;
      m_skip = int'(REDIRECT_PC[1]);
      if (!m_busy) begin
        m_busy = 1; m_stale = 0; m_addr = m_fpc;
      end else begin
        m_stale = 1;
      end
    end else begin
      sz = mq.size();
      if (sz > 0 && INST_READY) void'(mq.pop_front());
      if (m_busy) begin
        if (IACK) begin
          if (!m_stale) begin
            for (int h = m_skip; h < 2; h++) mq.push_back(m_addr + 32'(2 * h));
            m_fpc  = m_fpc + 4;
            m_skip = 0;
          end
          m_busy = 0; m_stale = 0;
        end
      end else if (8 - sz >= 2) begin
        m_busy = 1; m_addr = m_fpc;
      end
    end
  end

  // cycle-by-cycle comparison against the model
  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("ireq", 32'(IREQ), 32'(m_busy));
      chk("iaddr", IADDR, m_addr);
      chk("irw", 32'(IRW), 32'h0);
      chk("inst_valid", 32'(INST_VALID), 32'(mq.size() != 0));
      chk("occupancy", 32'(u_dut.count), 32'(mq.size()));
      if (mq.size() > 8) chk("no_overflow", 32'(mq.size()), 32'd8);
      if (mq.size() != 0) begin
        chk("inst_pc", INST_PC, mq[0]);
        chk("inst", 32'(INST), 32'(exp_hw(mq[0])));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    logic [31:0] got[$];

    cyc(1);
    cmp_en = 1;
    cyc(1);
    // reset values
    chk("rst_ireq", 32'(IREQ), 32'h0);
    chk("rst_iaddr", IADDR, 32'h0);
    chk("rst_valid", 32'(INST_VALID), 32'h0);
    chk("rst_inst", 32'(INST), 32'h0);
    chk("rst_inst_pc", INST_PC, 32'h0);

    // zero-wait streaming, consumer always ready
    RST = 1'b0;
    cyc(1);
    chk("first_ireq", 32'(IREQ), 32'h1);
    chk("first_iaddr", IADDR, 32'h0);
    chk("first_valid", 32'(INST_VALID), 32'h0);
    cyc(1);
    chk("first_inst_valid", 32'(INST_VALID), 32'h1);
    chk("first_inst_pc", INST_PC, 32'h0);
    for (int k = 1; k <= 6; k++) begin
      cyc(1);
      chk("stream_valid", 32'(INST_VALID), 32'h1);
      chk("stream_pc", INST_PC, 32'(2 * k));
    end

    // consumer stalled: queue fills, requests stop
    INST_READY = 1'b0;
    cyc(20);
    chk("stall_ireq", 32'(IREQ), 32'h0);
    chk("stall_valid", 32'(INST_VALID), 32'h1);
    INST_READY = 1'b1;
    cyc(20);

    // unaligned redirect from IDLE
    for (int k = 0; k < 20 && IREQ !== 1'b0; k++) cyc(1);
    chk("c_idle_found", 32'(IREQ), 32'h0);
    REDIRECT = 1'b1; REDIRECT_PC = 32'h0000_0103;
    cyc(1);
    REDIRECT = 1'b0;
    chk("c_ireq", 32'(IREQ), 32'h1);
    chk("c_iaddr", IADDR, 32'h0000_0100);
    chk("c_valid", 32'(INST_VALID), 32'h0);
    cyc(1);
    chk("c_first_valid", 32'(INST_VALID), 32'h1);
    chk("c_first_pc", INST_PC, 32'h0000_0102);
    chk("c_first_inst", 32'(INST), 32'h0);
    cyc(2);
    chk("c_next_pc", INST_PC, 32'h0000_0104);
    chk("c_next_inst", 32'(INST), 32'h0000_0104);

    // redirect while BUSY with 3 wait cycles
    mem_mode = 1; wait_n = 3;
    for (int k = 0; k < 20 && IREQ !== 1'b0; k++) cyc(1);
    for (int k = 0; k < 20 && IREQ !== 1'b1; k++) cyc(1);
    chk("d_busy_found", 32'(IREQ), 32'h1);
    REDIRECT = 1'b1; REDIRECT_PC = 32'h0000_0200;
    cyc(1);
    REDIRECT = 1'b0;
    chk("d_flush_ireq", 32'(IREQ), 32'h1);
    chk("d_flush_valid", 32'(INST_VALID), 32'h0);
    for (int k = 0; k < 20 && IREQ !== 1'b0; k++) cyc(1);
    chk("d_stale_done", 32'(IREQ), 32'h0);
    cyc(1);
    chk("d_new_ireq", 32'(IREQ), 32'h1);
    chk("d_new_iaddr", IADDR, 32'h0000_0200);
    cyc(30);

    // randomized traffic
    mem_mode = 2;
    for (int c = 0; c < 3000; c++) begin
      INST_READY  = ($urandom_range(3) != 0);
      REDIRECT    = ($urandom_range(24) == 0);
      REDIRECT_PC = $urandom;
      RST         = ($urandom_range(199) == 0);
      cyc(1);
    end
    REDIRECT = 1'b0; RST = 1'b0; INST_READY = 1'b1;

    // reset while a request is outstanding and five entries are queued
    RST = 1'b1; INST_READY = 1'b0; mem_mode = 0;
    cyc(1);
    RST = 1'b0; REDIRECT = 1'b1; REDIRECT_PC = 32'h0000_0302;
    cyc(1);
    REDIRECT = 1'b0;
    found = 0;
    for (int k = 0; k < 30 && !found; k++) begin
      if (mq.size() == 5) mem_mode = 3;
      if (mq.size() == 5 && IREQ === 1'b1) found = 1;
      else cyc(1);
    end
    chk("f_setup_found", 32'(found), 32'h1);
    chk("f_valid_before", 32'(INST_VALID), 32'h1);
    RST = 1'b1;
    cyc(1);
    chk("f_rst_ireq", 32'(IREQ), 32'h0);
    chk("f_rst_valid", 32'(INST_VALID), 32'h0);
    RST = 1'b0; mem_mode = 0; INST_READY = 1'b1;
    cyc(1);
    chk("f_restart_ireq", 32'(IREQ), 32'h1);
    chk("f_restart_iaddr", IADDR, 32'h0);
    cyc(10);

    // 64-bit bus: unaligned redirect keeps only the last halfword
    for (int k = 0; k < 20 && ireq64 !== 1'b0; k++) cyc(1);
    chk("w_idle_found", 32'(ireq64), 32'h0);
    redir64 = 1'b1; rpc64 = 32'h0000_0046;
    cyc(1);
    redir64 = 1'b0;
    chk("w_ireq", 32'(ireq64), 32'h1);
    chk("w_iaddr", iaddr64, 32'h0000_0040);
    chk("w_valid", 32'(valid64), 32'h0);
    cyc(1);
    chk("w_first_valid", 32'(valid64), 32'h1);
    chk("w_first_pc", pc64, 32'h0000_0046);
    chk("w_first_inst", 32'(inst64), 32'h0000_0046);
    for (int k = 0; k < 20 && got.size() < 4; k++) begin
      cyc(1);
      if (valid64 === 1'b1) got.push_back(pc64);
    end
    chk("w_count", 32'(got.size()), 32'd4);
    if (got.size() == 4) begin
      chk("w_pc0", got[0], 32'h0000_0048);
      chk("w_pc1", got[1], 32'h0000_004A);
      chk("w_pc2", got[2], 32'h0000_004C);
      chk("w_pc3", got[3], 32'h0000_004E);
    end

    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
